// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed driver for a bank of common-anode 7-segment
//             digits. Holds NUM_DIGITS hex nibbles, scans one digit per slot,
//             decodes to active-low a..g with per-digit decimal point,
//             blanking and leading-zero suppression. New values are captured
//             through a load handshake and applied only at frame boundaries
//             so a frame never mixes old and new digits.
//
//  Ports    :
//    clk          in   system clock, rising edge
//    rst_n        in   synchronous active-low reset
//    load         in   capture value/dp_in/blank_mask this cycle
//    value        in   packed hex nibbles, digit 0 in bits [3:0]
//    dp_in        in   per-digit decimal point request, active-high
//    blank_mask   in   per-digit force-dark, active-high
//    lz_suppress  in   live leading-zero suppression enable
//    seg          out  {g,f,e,d,c,b,a}, active-low
//    dp           out  decimal point, active-low
//    an           out  anode enables, active-low, at most one low
//    busy         out  a loaded value is waiting for the frame boundary
//    load_ack     out  one-cycle pulse when a pending value goes live
//    frame_done   out  one-cycle pulse after each complete scan
//
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    busy,
    output logic                    load_ack,
    output logic                    frame_done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IW = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(REFRESH_DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(NUM_DIGITS - 1);
    localparam logic [6:0]      c_SEG_OFF  = 7'h7F;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_CW-1:0]          r_cnt;
    logic [c_IW-1:0]          r_idx;

    logic [4*NUM_DIGITS-1:0]  r_pend_val;
    logic [NUM_DIGITS-1:0]    r_pend_dp;
    logic [NUM_DIGITS-1:0]    r_pend_blank;
    logic                     r_pend_valid;

    logic [4*NUM_DIGITS-1:0]  r_disp_val;
    logic [NUM_DIGITS-1:0]    r_disp_dp;
    logic [NUM_DIGITS-1:0]    r_disp_blank;

    // Boundary events, one cycle old; the output stage delays them once more
    // so frame_done/load_ack line up with the other registered outputs.
    logic                     r_frame_evt;
    logic                     r_xfer_evt;

    logic [6:0]               r_seg;
    logic                     r_dp;
    logic [NUM_DIGITS-1:0]    r_an;
    logic                     r_load_ack;
    logic                     r_frame_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                     w_cnt_last;
    logic                     w_idx_last;
    logic                     w_boundary;
    logic                     w_guard;
    logic [3:0]               w_nibs [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]    w_zero;
    logic [NUM_DIGITS-1:0]    w_lz_run;
    logic [3:0]               w_nib;
    logic [6:0]               w_dec;
    logic                     w_lz_dark;
    logic                     w_dark;
    logic [NUM_DIGITS-1:0]    w_an_sel;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_idx_last = (r_idx == c_IDX_LAST);
    assign w_boundary = w_cnt_last && w_idx_last;

    // With GUARD = 0 the comparison would be constant-false on an unsigned
    // counter, so the dark interval is removed structurally instead.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard = 1'b0;
        end else begin : g_guard
            localparam logic [c_CW-1:0] c_GUARD = c_CW'(GUARD);
            assign w_guard = (r_cnt < c_GUARD);
        end
    endgenerate

    // Split the displayed vector into per-digit nibbles.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign w_nibs[gi] = r_disp_val[4*gi +: 4];
            assign w_zero[gi] = (r_disp_val[4*gi +: 4] == 4'h0);
        end
    endgenerate

    // w_lz_run[i] is set when digit i and every digit above it are zero.
    always_comb begin
        w_lz_run = '0;
        w_lz_run[NUM_DIGITS-1] = w_zero[NUM_DIGITS-1];
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            w_lz_run[i] = w_zero[i] && w_lz_run[i+1];
        end
    end

    assign w_nib = w_nibs[r_idx];

    // Digit 0 always shows something, otherwise an all-zero value would
    // leave the whole display dark.
    assign w_lz_dark = lz_suppress && w_lz_run[r_idx] && (r_idx != '0);
    assign w_dark    = r_disp_blank[r_idx] || w_lz_dark;

    always_comb begin
        w_an_sel        = '1;
        w_an_sel[r_idx] = 1'b0;
    end

    // Hex to active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_dec = c_SEG_OFF;
        case (w_nib)
            4'h0: w_dec = 7'b1000000;
            4'h1: w_dec = 7'b1111001;
            4'h2: w_dec = 7'b0100100;
            4'h3: w_dec = 7'b0110000;
            4'h4: w_dec = 7'b0011001;
            4'h5: w_dec = 7'b0010010;
            4'h6: w_dec = 7'b0000010;
            4'h7: w_dec = 7'b1111000;
            4'h8: w_dec = 7'b0000000;
            4'h9: w_dec = 7'b0010000;
            4'hA: w_dec = 7'b0001000;
            4'hB: w_dec = 7'b0000011;
            4'hC: w_dec = 7'b1000110;
            4'hD: w_dec = 7'b0100001;
            4'hE: w_dec = 7'b0000110;
            4'hF: w_dec = 7'b0001110;
            default: w_dec = c_SEG_OFF;
        endcase
    end

    // ------------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Load handshake: pending set, display set, boundary transfer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_valid <= 1'b0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
            r_frame_evt  <= 1'b0;
            r_xfer_evt   <= 1'b0;
        end else begin
            r_frame_evt <= w_boundary;
            r_xfer_evt  <= w_boundary && (load || r_pend_valid);

            if (w_boundary) begin
                // A load landing on the boundary edge bypasses pending and
                // supersedes anything still waiting there.
                if (load) begin
                    r_disp_val   <= value;
                    r_disp_dp    <= dp_in;
                    r_disp_blank <= blank_mask;
                end else if (r_pend_valid) begin
                    r_disp_val   <= r_pend_val;
                    r_disp_dp    <= r_pend_dp;
                    r_disp_blank <= r_pend_blank;
                end
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend_val   <= value;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_mask;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs (one cycle behind counters/display state)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg        <= c_SEG_OFF;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_load_ack   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_load_ack   <= r_xfer_evt;
            r_frame_done <= r_frame_evt;
            if (w_guard) begin
                r_seg <= c_SEG_OFF;
                r_dp  <= 1'b1;
                r_an  <= '1;
            end else begin
                // A dark digit keeps its anode on so the slot timing and
                // average brightness of the other digits do not change.
                r_an  <= w_an_sel;
                r_seg <= w_dark ? c_SEG_OFF : w_dec;
                r_dp  <= w_dark || !r_disp_dp[r_idx];
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign busy       = r_pend_valid;
    assign load_ack   = r_load_ack;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Directed self-checking bench for seg7_scan_driver with
//             NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2. Cycle k is the k-th
//             rising edge after reset release; outputs sampled on the
//             following falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GD = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_mask = '0;
    logic          lz_suppress = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          busy;
    logic          load_ack;
    logic          frame_done;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD       (GD)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .busy        (busy),
        .load_ack    (load_ack),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0;
        blank_mask = '0; lz_suppress = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp_in = d; blank_mask = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; load = 1'b1; value = 16'hFFFF;
        repeat (3) @(negedge clk);
        load = 1'b0;
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", load_ack); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        value = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int          cy [9] = '{1, 2, 3, 8, 9, 11, 16, 17, 32};
        logic [3:0]  ea [9] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hF, 4'h7};
        logic [6:0]  es [9] = '{7'h7F, 7'h7F, 7'h40, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h7F, 7'h40};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wait_cyc(cy[i]);
            checks++; if (an !== ea[i]) begin failures++; $display("FAIL scan_an c%0d got=%b exp=%b", cy[i], an, ea[i]); end
            checks++; if (seg !== es[i]) begin failures++; $display("FAIL scan_seg c%0d got=%h exp=%h", cy[i], seg, es[i]); end
        end
        for (int k = 33; k <= 66; k++) begin
            wait_cyc(k);
            checks++;
            if (frame_done !== ((k == 33) || (k == 65))) begin
                failures++; $display("FAIL scan_frame_done c%0d got=%b exp=%b", k, frame_done, (k == 33) || (k == 65));
            end
        end
    endtask

    task automatic test_load();
        do_reset();
        wait_cyc(4);
        pulse_load(16'h12AF, 4'h0, 4'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL load_busy_c5 got=%b exp=1", busy); end
        wait_cyc(11);
        checks++; if (seg !== 7'h40) begin failures++; $display("FAIL load_old_frame got=%h exp=40", seg); end
        wait_cyc(31);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL load_busy_c31 got=%b exp=1", busy); end
        wait_cyc(32);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL load_busy_c32 got=%b exp=0", busy); end
        checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL load_ack_c32 got=%b exp=0", load_ack); end
        wait_cyc(33);
        checks++; if (load_ack !== 1'b1) begin failures++; $display("FAIL load_ack_c33 got=%b exp=1", load_ack); end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL load_fd_c33 got=%b exp=1", frame_done); end
        wait_cyc(34);
        checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL load_ack_c34 got=%b exp=0", load_ack); end
        wait_cyc(35);
        checks++; if (an !== 4'hE) begin failures++; $display("FAIL load_an_d0 got=%b exp=1110", an); end
        checks++; if (seg !== 7'b0001110) begin failures++; $display("FAIL load_seg_d0 got=%b exp=0001110", seg); end
        wait_cyc(43);
        checks++; if (seg !== 7'b0001000) begin failures++; $display("FAIL load_seg_d1 got=%b exp=0001000", seg); end
        wait_cyc(51);
        checks++; if (seg !== 7'b0100100) begin failures++; $display("FAIL load_seg_d2 got=%b exp=0100100", seg); end
        wait_cyc(59);
        checks++; if (an !== 4'h7) begin failures++; $display("FAIL load_an_d3 got=%b exp=0111", an); end
        checks++; if (seg !== 7'b1111001) begin failures++; $display("FAIL load_seg_d3 got=%b exp=1111001", seg); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        do_reset();
        while (cyc < 40) begin
            @(negedge clk);
            if (load_ack === 1'b1) acks++;
            load  = (cyc == 4) || (cyc == 10);
            value = (cyc == 4) ? 16'h0001 : 16'h0040;
        end
        load = 1'b0;
        checks++; if (acks != 1) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=1", acks); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", busy); end
        wait_cyc(43);
        checks++; if (seg !== 7'b0011001) begin failures++; $display("FAIL b2b_seg_d1 got=%b exp=0011001", seg); end
        wait_cyc(51);
        checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL b2b_seg_d2 got=%b exp=1000000", seg); end
        wait_cyc(59);
        checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL b2b_seg_d3 got=%b exp=1000000", seg); end
        wait_cyc(65);
        checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL b2b_no_second_ack got=%b exp=0", load_ack); end
    endtask

    task automatic test_lz();
        do_reset();
        lz_suppress = 1'b1;
        wait_cyc(4);
        pulse_load(16'h0040, 4'h0, 4'h0);
        checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL lz_zero_d0 got=%b exp=1000000", seg); end
        wait_cyc(11);
        checks++; if (an !== 4'hD) begin failures++; $display("FAIL lz_zero_an_d1 got=%b exp=1101", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL lz_zero_d1 got=%h exp=7f", seg); end
        wait_cyc(35);
        checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL lz_d0 got=%b exp=1000000", seg); end
        wait_cyc(43);
        checks++; if (seg !== 7'b0011001) begin failures++; $display("FAIL lz_d1 got=%b exp=0011001", seg); end
        wait_cyc(51);
        checks++; if (an !== 4'hB) begin failures++; $display("FAIL lz_an_d2 got=%b exp=1011", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL lz_d2 got=%h exp=7f", seg); end
        wait_cyc(59);
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL lz_d3 got=%h exp=7f", seg); end
        lz_suppress = 1'b0;
        wait_cyc(60);
        checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL lz_live_off got=%b exp=1000000", seg); end
    endtask

    task automatic test_blank_dp();
        do_reset();
        wait_cyc(4);
        pulse_load(16'h1234, 4'b0001, 4'b0100);
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL bdp_old_dp got=%b exp=1", dp); end
        wait_cyc(34);
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL bdp_guard_dp got=%b exp=1", dp); end
        wait_cyc(35);
        checks++; if (dp !== 1'b0) begin failures++; $display("FAIL bdp_d0_dp got=%b exp=0", dp); end
        checks++; if (seg !== 7'b0011001) begin failures++; $display("FAIL bdp_d0_seg got=%b exp=0011001", seg); end
        wait_cyc(40);
        checks++; if (dp !== 1'b0) begin failures++; $display("FAIL bdp_d0_dp_end got=%b exp=0", dp); end
        wait_cyc(41);
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL bdp_after_d0_dp got=%b exp=1", dp); end
        wait_cyc(43);
        checks++; if (seg !== 7'b0110000) begin failures++; $display("FAIL bdp_d1_seg got=%b exp=0110000", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL bdp_d1_dp got=%b exp=1", dp); end
        wait_cyc(51);
        checks++; if (an !== 4'hB) begin failures++; $display("FAIL bdp_d2_an got=%b exp=1011", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL bdp_d2_seg got=%h exp=7f", seg); end
        wait_cyc(59);
        checks++; if (seg !== 7'b1111001) begin failures++; $display("FAIL bdp_d3_seg got=%b exp=1111001", seg); end
    endtask

    task automatic test_boundary_load();
        do_reset();
        wait_cyc(4);
        pulse_load(16'h1111, 4'h0, 4'h0);
        wait_cyc(31);
        pulse_load(16'h5678, 4'h0, 4'h0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bnd_busy got=%b exp=0", busy); end
        checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL bnd_ack_c32 got=%b exp=0", load_ack); end
        wait_cyc(33);
        checks++; if (load_ack !== 1'b1) begin failures++; $display("FAIL bnd_ack_c33 got=%b exp=1", load_ack); end
        wait_cyc(34);
        checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL bnd_ack_c34 got=%b exp=0", load_ack); end
        wait_cyc(35);
        checks++; if (seg !== 7'b0000000) begin failures++; $display("FAIL bnd_d0 got=%b exp=0000000", seg); end
        wait_cyc(43);
        checks++; if (seg !== 7'b1111000) begin failures++; $display("FAIL bnd_d1 got=%b exp=1111000", seg); end
        wait_cyc(51);
        checks++; if (seg !== 7'b0000010) begin failures++; $display("FAIL bnd_d2 got=%b exp=0000010", seg); end
        wait_cyc(59);
        checks++; if (seg !== 7'b0010010) begin failures++; $display("FAIL bnd_d3 got=%b exp=0010010", seg); end
        wait_cyc(65);
        checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL bnd_ack_c65 got=%b exp=0", load_ack); end
    endtask

    task automatic test_reset_pending();
        int acks = 0;
        do_reset();
        wait_cyc(4);
        pulse_load(16'h9999, 4'hF, 4'h0);
        wait_cyc(10);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstp_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstp_busy_in_reset got=%b exp=0", busy); end
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL rstp_an_in_reset got=%b exp=1111", an); end
        rst_n = 1'b1;
        while (cyc < 40) begin
            @(negedge clk);
            if (load_ack === 1'b1) acks++;
        end
        checks++; if (acks != 0) begin failures++; $display("FAIL rstp_ack_count got=%0d exp=0", acks); end
        wait_cyc(43);
        checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL rstp_d1 got=%b exp=1000000", seg); end
        wait_cyc(59);
        checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL rstp_d3 got=%b exp=1000000", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL rstp_d3_dp got=%b exp=1", dp); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_lz();
        test_blank_dp();
        test_boundary_load();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
